// File: rtl/ctrl_pkg.sv
// Shared definitions for the user-control input conditioner: debounce default,
// per-channel FSM encoding and mode-select values.
package ctrl_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } db_state_e;

   localparam logic MODE_A = 1'b0;
   localparam logic MODE_B = 1'b1;

endpackage

// File: rtl/debounce_vec.sv
// One W-bit control channel: 2-flop synchroniser followed by a debounce FSM that
// commits a new word only after it has been seen unchanged for DEBOUNCE_CYCLES samples.
import ctrl_pkg::*;

module debounce_vec #(
   parameter int W               = 1,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] out_o,
   output logic         changed_o
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]     s1_q, s2_q;
   logic [W-1:0]     out_q, out_d;
   logic [W-1:0]     cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   db_state_e        state_q, state_d;
   logic             changed_q;

   // Synchroniser flops are deliberately unreset so reset can reload outputs from s2.
   always_ff @(posedge clk) begin
      s1_q <= raw_i;
      s2_q <= s1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         out_q     <= s2_q;
         cand_q    <= s2_q;
         cnt_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         changed_q <= (out_d != out_q);
      end
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (s2_q != out_q) begin
               state_d = PENDING;
               cand_d  = s2_q;
               cnt_d   = CNT_W'(1);
            end
         end
         PENDING: begin
            if (s2_q == out_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (s2_q != cand_q) begin
               cand_d = s2_q;
               cnt_d  = CNT_W'(1);
            end else if (cnt_q == CNT_LAST) begin
               out_d   = cand_q;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_o     = out_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/control_input_conditioner.sv
// User-control front end: debounces ModeSel and the TimeControl word independently
// and emits a single registered pulse whenever either debounced output changes.
import ctrl_pkg::*;

module control_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ModeSel_raw,
   input  logic [2:0] TimeControl_raw,
   output logic       ModeSel,
   output logic [2:0] TimeControl,
   output logic       ctrl_update
);

   logic mode_chg, tc_chg;
   logic ctrl_update_q, ctrl_update_d;

   debounce_vec #(
      .W               (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_mode (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (ModeSel_raw),
      .out_o     (ModeSel),
      .changed_o (mode_chg)
   );

   debounce_vec #(
      .W               (3),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_time (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (TimeControl_raw),
      .out_o     (TimeControl),
      .changed_o (tc_chg)
   );

   // Both channels committing on the same edge merge into one pulse.
   assign ctrl_update_d = mode_chg | tc_chg;

   always_ff @(posedge clk) begin
      if (rst) ctrl_update_q <= 1'b0;
      else     ctrl_update_q <= ctrl_update_d;
   end

   assign ctrl_update = ctrl_update_q;

endmodule

// File: tb/tb_control_input_conditioner.sv
// Directed and randomized checks of the control input conditioner against a
// window-based reference model (DEBOUNCE_CYCLES = 4).
module tb_control_input_conditioner;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       ModeSel_raw;
   logic [2:0] TimeControl_raw;
   logic       ModeSel;
   logic [2:0] TimeControl;
   logic       ctrl_update;

   control_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk             (clk),
      .rst             (rst),
      .ModeSel_raw     (ModeSel_raw),
      .TimeControl_raw (TimeControl_raw),
      .ModeSel         (ModeSel),
      .TimeControl     (TimeControl),
      .ctrl_update     (ctrl_update)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int upd_seen = 0;
   bit seen_011 = 1'b0;

   // Reference model: raw sample history, per-channel window of synchronised samples
   int ms_hist[$];
   int tc_hist[$];
   int ms_win[$];
   int tc_win[$];
   int exp_ms, exp_tc;
   bit exp_upd = 1'b0;
   bit chg_prev = 1'b0;

   task automatic model_edge();
      int s_ms, s_tc;
      bit chg, ok;
      ms_hist.push_back(int'(ModeSel_raw));
      tc_hist.push_back(int'(TimeControl_raw));
      s_ms = ms_hist[ms_hist.size()-3];
      s_tc = tc_hist[tc_hist.size()-3];
      if (ms_hist.size() > 8) ms_hist.pop_front();
      if (tc_hist.size() > 8) tc_hist.pop_front();
      chg = 1'b0;
      if (rst) begin
         exp_ms = s_ms;
         exp_tc = s_tc;
         ms_win.delete();
         tc_win.delete();
         exp_upd = 1'b0;
      end else begin
         ms_win.push_back(s_ms);
         if (ms_win.size() > DC) ms_win.pop_front();
         tc_win.push_back(s_tc);
         if (tc_win.size() > DC) tc_win.pop_front();
         ok = (ms_win.size() == DC);
         foreach (ms_win[i]) if (ms_win[i] != ms_win[0]) ok = 1'b0;
         if (ok && ms_win[0] != exp_ms) begin exp_ms = ms_win[0]; chg = 1'b1; end
         ok = (tc_win.size() == DC);
         foreach (tc_win[i]) if (tc_win[i] != tc_win[0]) ok = 1'b0;
         if (ok && tc_win[0] != exp_tc) begin exp_tc = tc_win[0]; chg = 1'b1; end
         exp_upd = chg_prev;
      end
      chg_prev = chg;
   endtask

   task automatic tick(input bit do_check);
      @(posedge clk);
      model_edge();
      #1;
      if (ctrl_update === 1'b1) upd_seen++;
      if (TimeControl === 3'b011) seen_011 = 1'b1;
      if (do_check) begin
         n_cmp++;
         assert (ModeSel === exp_ms[0]) else begin
            n_err++;
            $error("FAIL model_ms t=%0t got %b exp %0d", $time, ModeSel, exp_ms);
         end
         n_cmp++;
         assert (TimeControl === exp_tc[2:0]) else begin
            n_err++;
            $error("FAIL model_tc t=%0t got %b exp %0d", $time, TimeControl, exp_tc);
         end
         n_cmp++;
         assert (ctrl_update === exp_upd) else begin
            n_err++;
            $error("FAIL model_upd t=%0t got %b exp %b", $time, ctrl_update, exp_upd);
         end
      end
   endtask

   initial begin
      int ms_at, tc_at, lat, upd0, hold;

      rst = 1'b1;
      ModeSel_raw = 1'b1;
      TimeControl_raw = 3'b101;
      repeat (2) ms_hist.push_back(1);
      repeat (2) tc_hist.push_back(5);

      // Reset from the actual switch positions
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      tick(1'b1);
      rst = 1'b0;
      n_cmp++;
      assert (ModeSel === 1'b1) else begin n_err++; $error("FAIL rst_ms got %b exp 1", ModeSel); end
      n_cmp++;
      assert (TimeControl === 3'b101) else begin n_err++; $error("FAIL rst_tc got %b exp 101", TimeControl); end
      n_cmp++;
      assert (upd_seen == 0) else begin n_err++; $error("FAIL rst_upd got %0d pulses exp 0", upd_seen); end
      repeat (3) tick(1'b1);

      // Simultaneous change of both channels
      upd0 = upd_seen;
      ModeSel_raw = 1'b0;
      TimeControl_raw = 3'b000;
      ms_at = -1;
      tc_at = -1;
      for (int k = 1; k <= 12; k++) begin
         tick(1'b1);
         if (ms_at < 0 && ModeSel === 1'b0) ms_at = k;
         if (tc_at < 0 && TimeControl === 3'b000) tc_at = k;
      end
      n_cmp++;
      assert (ms_at == DC + 2 && tc_at == DC + 2) else begin
         n_err++; $error("FAIL simul_edge got ms@%0d tc@%0d exp both @%0d", ms_at, tc_at, DC + 2);
      end
      n_cmp++;
      assert (upd_seen - upd0 == 1) else begin
         n_err++; $error("FAIL simul_pulse got %0d exp 1", upd_seen - upd0);
      end

      // Clean step with latency measurement
      TimeControl_raw = 3'b011;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick(1'b1);
         if (TimeControl === 3'b011) begin lat = k; break; end
      end
      n_cmp++;
      assert (lat == DC + 2) else begin n_err++; $error("FAIL step_lat got %0d exp %0d", lat, DC + 2); end
      n_cmp++;
      assert (ctrl_update === 1'b0) else begin n_err++; $error("FAIL step_upd_early got %b exp 0", ctrl_update); end
      tick(1'b1);
      n_cmp++;
      assert (ctrl_update === 1'b1) else begin n_err++; $error("FAIL step_upd got %b exp 1", ctrl_update); end
      tick(1'b1);
      n_cmp++;
      assert (ctrl_update === 1'b0) else begin n_err++; $error("FAIL step_upd_end got %b exp 0", ctrl_update); end

      // Glitch on ModeSel shorter than the window
      upd0 = upd_seen;
      ModeSel_raw = 1'b1;
      repeat (3) tick(1'b1);
      ModeSel_raw = 1'b0;
      repeat (8) tick(1'b1);
      n_cmp++;
      assert (ModeSel === 1'b0 && upd_seen == upd0) else begin
         n_err++; $error("FAIL glitch got ms=%b pulses=%0d exp ms=0 pulses=0", ModeSel, upd_seen - upd0);
      end

      // Bounce on TimeControl
      TimeControl_raw = 3'b000;
      repeat (9) tick(1'b1);
      upd0 = upd_seen;
      seen_011 = 1'b0;
      TimeControl_raw = 3'b001;
      repeat (2) tick(1'b1);
      TimeControl_raw = 3'b011;
      repeat (2) tick(1'b1);
      TimeControl_raw = 3'b001;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick(1'b1);
         if (lat < 0 && TimeControl === 3'b001) lat = k;
      end
      n_cmp++;
      assert (lat == DC + 2) else begin n_err++; $error("FAIL bounce_lat got %0d exp %0d", lat, DC + 2); end
      n_cmp++;
      assert (!seen_011 && upd_seen - upd0 == 1) else begin
         n_err++; $error("FAIL bounce_clean got seen011=%b pulses=%0d exp 0/1", seen_011, upd_seen - upd0);
      end

      // Reset while ModeSel change is pending
      upd0 = upd_seen;
      ModeSel_raw = 1'b1;
      repeat (2) tick(1'b1);
      rst = 1'b1;
      repeat (3) tick(1'b1);
      rst = 1'b0;
      n_cmp++;
      assert (ModeSel === 1'b1) else begin n_err++; $error("FAIL rstpend_ms got %b exp 1", ModeSel); end
      repeat (8) tick(1'b1);
      n_cmp++;
      assert (upd_seen == upd0) else begin
         n_err++; $error("FAIL rstpend_pulse got %0d exp 0", upd_seen - upd0);
      end

      // Randomized hold lengths, values and occasional resets
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            repeat (3) tick(1'b1);
            rst = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) ModeSel_raw = 1'($urandom);
         if ($urandom_range(0, 2) != 0) TimeControl_raw = 3'($urandom);
         hold = $urandom_range(1, 7);
         repeat (hold) tick(1'b1);
      end
      repeat (10) tick(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
